pulse_gen_multi: RTL and testbench

- Multi-channel, parametrised edge-to-pulse generator.
- Each channel synchronises an asynchronous level input (button/switch), debounces it, detects the selected edge(s), and emits a single-cycle pulse.
- Optional per-channel one-shot mode: the channel fires once, then stays silent until explicitly re-armed.
- Sits between board I/O and control FSMs (counters, menus) that need exactly one event per press.

---
 rtl/pulse_gen_pkg.sv | 29 ++
 rtl/pulse_gen_multi_ch.sv | 94 +++++++++
 rtl/pulse_gen_multi.sv | 52 +++++
 tb/tb_pulse_gen_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// pulse_gen_pkg
// Shared definitions for the multi-channel edge-to-pulse generator.
//   MODE_*        : encoding of the common edge-select input
//   edge_qualify  : decides whether a newly accepted debounced level should
//                   produce an event under the selected mode
// ---------------------------------------------------------------------------
package pulse_gen_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // new_level is the value the debounced level is about to take, so a
    // rising edge is "new level is 1" and a falling edge is "new level is 0".
    function automatic logic edge_qualify(input logic [1:0] mode,
                                          input logic       new_level);
        logic q;
        case (mode)
            MODE_RISE: q = new_level;
            MODE_FALL: q = ~new_level;
            MODE_BOTH: q = 1'b1;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/pulse_gen_multi_ch.sv
// ---------------------------------------------------------------------------
// pulse_gen_ch
// One channel of the edge-to-pulse generator: synchroniser, debounce filter,
// edge qualification and one-shot arming.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_async      : raw asynchronous level input
//   mode          : common edge select (see pulse_gen_pkg)
//   oneshot_en    : one-shot enable for this channel
//   rearm         : synchronous re-arm strobe
//   pulse         : registered single-cycle event
//   level         : debounced stable level
//   armed         : armed flag (only meaningful when oneshot_en is set)
// ---------------------------------------------------------------------------
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_async,
    input  logic [1:0] mode,
    input  logic       oneshot_en,
    input  logic       rearm,
    output logic       pulse,
    output logic       level,
    output logic       armed
);

    localparam int               CNT_W    = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   armed_q, armed_d;
    logic                   s;
    logic                   fire;

    assign s = sync_q[SYNC_STAGES-1];

    // Input enters at bit 0 and shifts towards the last stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_async};
    end

    // The counter measures how long the synchronised input has disagreed
    // with the accepted level. Any agreement resets it, which is what
    // throws away glitches shorter than DB_CYCLES. The pulse uses the armed
    // value from before this edge, while armed itself is cleared by that
    // same pulse unless rearm is present, so rearm wins on a tie.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        fire    = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
            fire    = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        pulse_d = fire & edge_qualify(mode, s) & (armed_q | ~oneshot_en);
        armed_d = rearm | (armed_q & ~(pulse_d & oneshot_en));
    end

    // State register; armed comes out of reset set so the first event after
    // power-up is always delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            armed_q <= armed_d;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;
    assign armed = armed_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// ---------------------------------------------------------------------------
// pulse_gen_multi
// Multi-channel edge-to-pulse generator for buttons and switches. Each
// channel is synchronised, debounced and turned into a single-cycle event on
// the selected edge(s), with optional one-shot behaviour.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in          : [N_CH] raw asynchronous level inputs
//   mode        : edge select, shared: 00 rise, 01 fall, 10 both, 11 off
//   oneshot_en  : [N_CH] per-channel one-shot enable
//   rearm       : [N_CH] per-channel re-arm strobe
//   pulse       : [N_CH] one-cycle event pulses
//   level       : [N_CH] debounced levels
//   armed       : [N_CH] armed flags
// ---------------------------------------------------------------------------
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    input  logic [1:0]      mode,
    input  logic [N_CH-1:0] oneshot_en,
    input  logic [N_CH-1:0] rearm,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] armed
);

    // Channels are fully independent; only mode is shared between them.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_gen_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .in_async  (in[i]),
            .mode      (mode),
            .oneshot_en(oneshot_en[i]),
            .rearm     (rearm[i]),
            .pulse     (pulse[i]),
            .level     (level[i]),
            .armed     (armed[i])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen_multi
// Directed bench for pulse_gen_multi: one instance with default parameters
// (4 channels, 2 sync stages, 16-cycle debounce) and one with 8 channels,
// 3 sync stages and no debounce filtering. Inputs change on the falling edge,
// outputs are read on the falling edge, pulse counting happens 2 time units
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_pulse_gen_multi;
    import pulse_gen_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] in_a, oneshot_a, rearm_a, pulse_a, level_a, armed_a;
    logic [1:0] mode_a;
    logic [7:0] in_p, oneshot_p, rearm_p, pulse_p, level_p, armed_p;
    logic [1:0] mode_p;

    int tests_run    = 0;
    int tests_failed = 0;
    int cnt_a[4]     = '{default: 0};
    int cnt_p[8]     = '{default: 0};
    int wide_a       = 0;
    int wide_p       = 0;
    logic [3:0] prev_a = '0;
    logic [7:0] prev_p = '0;

    pulse_gen_multi dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_a),
        .mode      (mode_a),
        .oneshot_en(oneshot_a),
        .rearm     (rearm_a),
        .pulse     (pulse_a),
        .level     (level_a),
        .armed     (armed_a)
    );

    pulse_gen_multi #(
        .N_CH       (8),
        .SYNC_STAGES(3),
        .DB_CYCLES  (1)
    ) dut_p (
        .clk       (clk),
        .rst       (rst),
        .in        (in_p),
        .mode      (mode_p),
        .oneshot_en(oneshot_p),
        .rearm     (rearm_p),
        .pulse     (pulse_p),
        .level     (level_p),
        .armed     (armed_p)
    );

    // Pulse counters and width watchdog, sampled just after each rising edge.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 4; i++) if (pulse_a[i]) cnt_a[i]++;
        for (int i = 0; i < 8; i++) if (pulse_p[i]) cnt_p[i]++;
        if ((pulse_a & prev_a) != 4'b0) wide_a++;
        if ((pulse_p & prev_p) != 8'b0) wide_p++;
        prev_a = pulse_a;
        prev_p = pulse_p;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive the default instance's inputs and hold them for a number of cycles.
    task automatic applyStimulus(input logic [3:0] new_in, input int hold);
        in_a = new_in;
        repeat (hold) @(negedge clk);
    endtask

    int c;
    int exp_press[4] = '{1, 0, 1, 0};
    int exp_rel[4]   = '{0, 1, 1, 0};
    int base_p[8];
    int exp_p[8];
    logic [7:0] nxt;

    initial begin
        rst       = 1'b1;
        in_a      = '0;
        mode_a    = MODE_RISE;
        oneshot_a = '0;
        rearm_a   = '0;
        in_p      = '0;
        mode_p    = MODE_BOTH;
        oneshot_p = '0;
        rearm_p   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_pulse", pulse_a, 4'h0);
        checkOutput("rst_level", level_a, 4'h0);
        checkOutput("rst_armed", armed_a, 4'hF);
        rst = 1'b0;

        // Run with one-shot on channels 1 and 3 so armed is cleared before reset.
        oneshot_a = 4'b1010;
        applyStimulus(4'b1010, 25);
        checkOutput("pre_level", level_a, 4'b1010);
        checkOutput("pre_armed", armed_a, 4'b0101);
        checkOutput("pre_cnt1", cnt_a[1], 1);
        checkOutput("pre_cnt3", cnt_a[3], 1);

        // Asynchronous reset away from any clock edge.
        #2 rst = 1'b1;
        #1;
        checkOutput("async_pulse", pulse_a, 4'h0);
        checkOutput("async_level", level_a, 4'h0);
        checkOutput("async_armed", armed_a, 4'hF);
        @(negedge clk);
        @(negedge clk);
        oneshot_a = '0;
        rst = 1'b0;
        repeat (17) @(negedge clk);
        checkOutput("rel_pulse_early", pulse_a, 4'h0);
        checkOutput("rel_level_early", level_a, 4'h0);
        @(negedge clk);
        checkOutput("rel_pulse", pulse_a, 4'b1010);
        checkOutput("rel_level", level_a, 4'b1010);
        @(negedge clk);
        checkOutput("rel_pulse_end", pulse_a, 4'h0);

        // Exact latency on channel 0 rising.
        mode_a = MODE_RISE;
        in_a   = 4'b1011;
        repeat (17) @(negedge clk);
        checkOutput("lat_ch0_early", pulse_a[0], 1'b0);
        @(negedge clk);
        checkOutput("lat_ch0_pulse", pulse_a[0], 1'b1);
        checkOutput("lat_ch0_level", level_a[0], 1'b1);
        @(negedge clk);
        checkOutput("lat_ch0_end", pulse_a[0], 1'b0);
        repeat (5) @(negedge clk);

        // 10-cycle low glitch on channel 0 with both edges enabled.
        mode_a = MODE_BOTH;
        c = cnt_a[0];
        applyStimulus(4'b1010, 10);
        checkOutput("glitch_level_mid", level_a[0], 1'b1);
        applyStimulus(4'b1011, 30);
        checkOutput("glitch_level", level_a[0], 1'b1);
        checkOutput("glitch_pulses", cnt_a[0] - c, 0);

        // One press/release on channel 2 in every mode.
        for (int m = 0; m < 4; m++) begin
            mode_a = 2'(m);
            c = cnt_a[2];
            applyStimulus(4'b1111, 30);
            checkOutput($sformatf("mode%0d_press_lvl", m), level_a[2], 1'b1);
            checkOutput($sformatf("mode%0d_press", m), cnt_a[2] - c, exp_press[m]);
            c = cnt_a[2];
            applyStimulus(4'b1011, 30);
            checkOutput($sformatf("mode%0d_rel_lvl", m), level_a[2], 1'b0);
            checkOutput($sformatf("mode%0d_rel", m), cnt_a[2] - c, exp_rel[m]);
        end

        // One-shot on channel 1: three presses give one pulse.
        mode_a    = MODE_RISE;
        oneshot_a = 4'b0010;
        c = cnt_a[1];
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1001, 30);
            applyStimulus(4'b1011, 30);
        end
        checkOutput("os_three_presses", cnt_a[1] - c, 1);
        checkOutput("os_disarmed", armed_a[1], 1'b0);
        checkOutput("os_ch0_armed", armed_a[0], 1'b1);
        rearm_a = 4'b0010;
        @(negedge clk);
        rearm_a = '0;
        checkOutput("os_rearmed", armed_a[1], 1'b1);
        c = cnt_a[1];
        applyStimulus(4'b1001, 30);
        applyStimulus(4'b1011, 30);
        checkOutput("os_fourth_press", cnt_a[1] - c, 1);
        checkOutput("os_disarmed2", armed_a[1], 1'b0);

        // Rearm coinciding with acceptance while armed.
        rearm_a = 4'b0010;
        @(negedge clk);
        rearm_a = '0;
        applyStimulus(4'b1001, 30);
        in_a = 4'b1011;
        repeat (17) @(negedge clk);
        rearm_a = 4'b0010;
        @(negedge clk);
        checkOutput("sim_armed_pulse", pulse_a[1], 1'b1);
        checkOutput("sim_armed_flag", armed_a[1], 1'b1);
        rearm_a = '0;
        @(negedge clk);
        checkOutput("sim_armed_hold", armed_a[1], 1'b1);

        // Consume the arm, then rearm coinciding with acceptance while disarmed.
        applyStimulus(4'b1001, 30);
        applyStimulus(4'b1011, 30);
        checkOutput("sim_consume", armed_a[1], 1'b0);
        applyStimulus(4'b1001, 30);
        in_a = 4'b1011;
        repeat (17) @(negedge clk);
        rearm_a = 4'b0010;
        @(negedge clk);
        checkOutput("sim_disarmed_pulse", pulse_a[1], 1'b0);
        checkOutput("sim_disarmed_flag", armed_a[1], 1'b1);
        rearm_a = '0;
        repeat (3) @(negedge clk);
        checkOutput("width_a", wide_a, 0);

        // Eight-channel instance, no debounce: random toggles held >= 2 cycles.
        for (int ph = 0; ph < 2; ph++) begin
            mode_p = (ph == 0) ? MODE_BOTH : MODE_RISE;
            for (int i = 0; i < 8; i++) begin
                base_p[i] = cnt_p[i];
                exp_p[i]  = 0;
            end
            for (int step = 0; step < 40; step++) begin
                nxt = in_p ^ 8'($urandom);
                for (int i = 0; i < 8; i++)
                    if (nxt[i] != in_p[i] && (ph == 0 || nxt[i])) exp_p[i]++;
                in_p = nxt;
                repeat ($urandom_range(2, 4)) @(negedge clk);
            end
            repeat (10) @(negedge clk);
            for (int i = 0; i < 8; i++)
                checkOutput($sformatf("p_ph%0d_ch%0d", ph, i), cnt_p[i] - base_p[i], exp_p[i]);
            checkOutput($sformatf("p_ph%0d_level", ph), level_p, in_p);
        end
        checkOutput("width_p", wide_p, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
